// File: rtl/iic_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// iic_xfer_ctrl
//   Sequences one complete I2C register transaction on top of a byte engine:
//   START+address, register pointer, then either write data bytes or a
//   repeated START+address(read) followed by read bytes, and finally STOP.
//   Write data is pulled from an upstream byte stream, read data is pushed
//   out as single-cycle pulses. NACK and per-operation timeout are reported.
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   mode               speed select, forwarded unchanged on m_mode
//   cmd_*              command request/accept (dev, reg, rw, len)
//   wr_valid/wr_data   write byte stream in, wr_ready pulses on consume
//   rd_valid/rd_data   read byte out, single-cycle pulse, no backpressure
//   busy, xfer_done    command in progress / completion pulse
//   err_nack,
//   err_timeout,
//   bytes_ok           status of the last command, held until next accept
//   m_*                byte engine request side (start/restart/stop/rw/
//                      last/data/mode) and response side (done/ack/rdata)
//
// States
//   IDLE      | waiting for a command, cmd_ready high
//   FETCH     | waiting for the next write byte from upstream
//   ISSUE     | raise a byte-op request once the engine is idle
//   WAIT_ACC  | hold request until engine starts (m_done low)
//   WAIT_DONE | wait for the engine to finish the byte op
//   CHECK     | evaluate ACK, count data bytes, choose the next phase
//   STOP_REQ  | raise a STOP request once the engine is idle
//   STOP_WAIT | STOP accept and completion
//   REPORT    | completion pulse, return to IDLE
// ---------------------------------------------------------------------------
module iic_xfer_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       xfer_done,
  output logic       err_nack,
  output logic       err_timeout,
  output logic [3:0] bytes_ok,
  output logic       m_start,
  output logic       m_restart,
  output logic       m_stop,
  output logic       m_rw,
  output logic       m_last,
  output logic [7:0] m_data,
  output logic [1:0] m_mode,
  input  logic       m_done,
  input  logic       m_ack,
  input  logic [7:0] m_rdata
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_CHECK,
    S_STOP_REQ,
    S_STOP_WAIT,
    S_REPORT
  } state_t;

  typedef enum logic [2:0] {
    P_AW,
    P_REG,
    P_WD,
    P_AR,
    P_RD
  } phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic          rw_q;
  logic [3:0]    len_q;
  logic [7:0]    wdata_q;
  logic [TW-1:0] tmo_q;

  logic          cmd_ready_q, busy_q, xfer_done_q, wr_ready_q, rd_valid_q;
  logic [7:0]    rd_data_q;
  logic          err_nack_q, err_timeout_q;
  logic [3:0]    bytes_ok_q;
  logic          m_start_q, m_restart_q, m_stop_q, m_rw_q, m_last_q;
  logic [7:0]    m_data_q;

  logic [7:0]    m_data_d;
  logic          data_last_d;
  logic          tmo_hit_d;

  // Byte presented to the engine for the current phase
  always_comb begin
    m_data_d = 8'h00;
    case (phase_q)
      P_AW:    m_data_d = {dev_q, 1'b0};
      P_REG:   m_data_d = reg_q;
      P_WD:    m_data_d = wdata_q;
      P_AR:    m_data_d = {dev_q, 1'b1};
      default: m_data_d = 8'h00;
    endcase
  end

  // bytes_ok doubles as the data byte index; it is always below len here
  assign data_last_d = ((bytes_ok_q + 4'd1) == len_q);
  assign tmo_hit_d   = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      phase_q       <= P_AW;
      dev_q         <= 7'h00;
      reg_q         <= 8'h00;
      rw_q          <= 1'b0;
      len_q         <= 4'h0;
      wdata_q       <= 8'h00;
      tmo_q         <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      xfer_done_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'h00;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      bytes_ok_q    <= 4'h0;
      m_start_q     <= 1'b0;
      m_restart_q   <= 1'b0;
      m_stop_q      <= 1'b0;
      m_rw_q        <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= 8'h00;
    end else begin
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      xfer_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            dev_q         <= cmd_dev;
            reg_q         <= cmd_reg;
            rw_q          <= cmd_rw;
            len_q         <= cmd_len;
            err_nack_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            bytes_ok_q    <= 4'h0;
            busy_q        <= 1'b1;
            cmd_ready_q   <= 1'b0;
            phase_q       <= P_AW;
            state_q       <= S_ISSUE;
          end
        end

        S_FETCH: begin
          if (wr_valid) begin
            wdata_q    <= wr_data;
            wr_ready_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (m_done) begin
            m_start_q   <= 1'b1;
            m_restart_q <= (phase_q == P_AW) || (phase_q == P_AR);
            m_rw_q      <= (phase_q == P_RD);
            m_last_q    <= (phase_q == P_RD) && data_last_d;
            m_data_q    <= m_data_d;
            tmo_q       <= '0;
            state_q     <= S_WAIT_ACC;
          end
        end

        S_WAIT_ACC: begin
          if (!m_done) begin
            m_start_q   <= 1'b0;
            m_restart_q <= 1'b0;
            m_last_q    <= 1'b0;
            tmo_q       <= '0;
            state_q     <= S_WAIT_DONE;
          end else if (tmo_hit_d) begin
            m_start_q     <= 1'b0;
            m_restart_q   <= 1'b0;
            m_last_q      <= 1'b0;
            err_timeout_q <= 1'b1;
            xfer_done_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_REPORT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_WAIT_DONE: begin
          if (m_done) begin
            // Read data is published on entry so rd_valid is high in CHECK
            if (phase_q == P_RD) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= m_rdata;
            end
            state_q <= S_CHECK;
          end else if (tmo_hit_d) begin
            err_timeout_q <= 1'b1;
            xfer_done_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_REPORT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_CHECK: begin
          if ((phase_q != P_RD) && m_ack) begin
            err_nack_q <= 1'b1;
            state_q    <= S_STOP_REQ;
          end else begin
            case (phase_q)
              P_AW: begin
                phase_q <= P_REG;
                state_q <= S_ISSUE;
              end
              P_REG: begin
                if (len_q == 4'h0) begin
                  state_q <= S_STOP_REQ;
                end else if (rw_q) begin
                  phase_q <= P_AR;
                  state_q <= S_ISSUE;
                end else begin
                  phase_q <= P_WD;
                  state_q <= S_FETCH;
                end
              end
              P_WD: begin
                bytes_ok_q <= bytes_ok_q + 4'd1;
                state_q    <= data_last_d ? S_STOP_REQ : S_FETCH;
              end
              P_AR: begin
                phase_q <= P_RD;
                state_q <= S_ISSUE;
              end
              P_RD: begin
                bytes_ok_q <= bytes_ok_q + 4'd1;
                state_q    <= data_last_d ? S_STOP_REQ : S_ISSUE;
              end
              default: state_q <= S_STOP_REQ;
            endcase
          end
        end

        S_STOP_REQ: begin
          if (m_done) begin
            m_stop_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= S_STOP_WAIT;
          end
        end

        // m_stop_q high = waiting for accept, low = waiting for completion
        S_STOP_WAIT: begin
          if (m_stop_q && !m_done) begin
            m_stop_q <= 1'b0;
            tmo_q    <= '0;
          end else if (!m_stop_q && m_done) begin
            xfer_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_REPORT;
          end else if (tmo_hit_d) begin
            m_stop_q      <= 1'b0;
            err_timeout_q <= 1'b1;
            xfer_done_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_REPORT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_REPORT: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign xfer_done   = xfer_done_q;
  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_nack    = err_nack_q;
  assign err_timeout = err_timeout_q;
  assign bytes_ok    = bytes_ok_q;
  assign m_start     = m_start_q;
  assign m_restart   = m_restart_q;
  assign m_stop      = m_stop_q;
  assign m_rw        = m_rw_q;
  assign m_last      = m_last_q;
  assign m_data      = m_data_q;
  assign m_mode      = mode;

endmodule

// File: tb/tb_iic_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iic_xfer_ctrl
//   Directed and randomized transactions against a behavioural byte-engine
//   model. Expected engine operations, data and status are derived from the
//   command alone (list of ops, truncated at a NACK, followed by STOP).
// ---------------------------------------------------------------------------
module tb_iic_xfer_ctrl;
  localparam int TMO = 100;

  logic       clk, rst;
  logic [1:0] mode;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic       cmd_rw;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, xfer_done, err_nack, err_timeout;
  logic [3:0] bytes_ok;
  logic       m_start, m_restart, m_stop, m_rw, m_last;
  logic [7:0] m_data;
  logic [1:0] m_mode;
  logic       m_done, m_ack;
  logic [7:0] m_rdata;

  iic_xfer_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .xfer_done(xfer_done), .err_nack(err_nack),
    .err_timeout(err_timeout), .bytes_ok(bytes_ok),
    .m_start(m_start), .m_restart(m_restart), .m_stop(m_stop),
    .m_rw(m_rw), .m_last(m_last), .m_data(m_data), .m_mode(m_mode),
    .m_done(m_done), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       stop;
    logic       restart;
    logic       rw;
    logic       last;
    logic [7:0] data;
  } op_t;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wdata_src [16];
  logic [7:0] rd_src    [16];
  logic [7:0] wr_q      [$];
  op_t        ops_got   [$];
  logic [7:0] rd_got    [$];
  int         wr_cnt, xfer_cnt;

  op_t        exp_ops   [$];
  int         exp_wr, exp_rd, exp_bytes;
  logic       exp_nack;

  int   nack_at;
  int   eng_idx, rd_idx;
  logic eng_hang;
  logic eng_busy, eng_is_read, eng_nack;
  int   eng_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic s, input logic r, input logic w,
                                input logic l, input logic [7:0] d);
    op_t o;
    o.stop = s; o.restart = r; o.rw = w; o.last = l; o.data = d;
    return o;
  endfunction

  // Reference: full op list for the command, cut after a NACKed send, plus STOP
  task automatic build_exp(input logic [6:0] dev, input logic [7:0] rg,
                           input logic rw, input int len, input int nk);
    op_t full [$];
    int  kind [$];   // 0 addr/reg, 1 write data, 2 read data
    exp_ops.delete();
    exp_wr = 0; exp_rd = 0; exp_bytes = 0; exp_nack = 1'b0;
    full.push_back(mk_op(1'b0, 1'b1, 1'b0, 1'b0, {dev, 1'b0})); kind.push_back(0);
    full.push_back(mk_op(1'b0, 1'b0, 1'b0, 1'b0, rg));          kind.push_back(0);
    if (len > 0) begin
      if (!rw) begin
        for (int i = 0; i < len; i++) begin
          full.push_back(mk_op(1'b0, 1'b0, 1'b0, 1'b0, wdata_src[i])); kind.push_back(1);
        end
      end else begin
        full.push_back(mk_op(1'b0, 1'b1, 1'b0, 1'b0, {dev, 1'b1})); kind.push_back(0);
        for (int i = 0; i < len; i++) begin
          full.push_back(mk_op(1'b0, 1'b0, 1'b1, (i == len - 1), 8'h00)); kind.push_back(2);
        end
      end
    end
    for (int i = 0; i < full.size(); i++) begin
      exp_ops.push_back(full[i]);
      if (kind[i] != 2 && i == nk) begin
        exp_nack = 1'b1;
        if (kind[i] == 1) exp_wr++;
        break;
      end
      if (kind[i] == 1) begin exp_wr++; exp_bytes++; end
      if (kind[i] == 2) begin exp_rd++; exp_bytes++; end
    end
    exp_ops.push_back(mk_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
  endtask

  // Byte engine model: accepts a request when idle, finishes 1..4 cycles later
  initial begin
    m_done = 1'b1; m_ack = 1'b0; m_rdata = 8'h00;
    eng_busy = 1'b0; eng_cnt = 0; eng_is_read = 1'b0; eng_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_done = 1'b1;
        eng_busy = 1'b0;
      end else if (!eng_busy) begin
        if (m_done && (m_start || m_stop)) begin
          chk("start_stop_exclusive", {m_start, m_stop}, (m_start ? 2'b10 : 2'b01));
          if (m_stop) ops_got.push_back(mk_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
          else ops_got.push_back(mk_op(1'b0, m_restart, m_rw, m_last, m_rw ? 8'h00 : m_data));
          eng_is_read = m_start && m_rw;
          eng_nack    = m_start && !m_rw && (eng_idx == nack_at);
          if (m_start) eng_idx++;
          m_done   = 1'b0;
          eng_busy = 1'b1;
          eng_cnt  = $urandom_range(0, 3);
        end
      end else if (!eng_hang) begin
        if (eng_cnt == 0) begin
          m_ack = eng_nack;
          if (eng_is_read) begin
            m_rdata = rd_src[rd_idx];
            rd_idx++;
          end else begin
            m_rdata = 8'($urandom);
          end
          m_done   = 1'b1;
          eng_busy = 1'b0;
        end else begin
          eng_cnt--;
        end
      end
    end
  end

  // Upstream write byte source
  initial begin
    wr_valid = 1'b0; wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() > 0);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wr_ready)  wr_cnt++;
        if (rd_valid)  rd_got.push_back(rd_data);
        if (xfer_done) xfer_cnt++;
      end
    end
  end

  task automatic start_cmd(input logic [6:0] dev, input logic [7:0] rg,
                           input logic rw, input int len);
    logic ok;
    ops_got.delete(); rd_got.delete(); wr_q.delete();
    wr_cnt = 0; xfer_cnt = 0; eng_idx = 0; rd_idx = 0;
    if (!rw) for (int i = 0; i < len; i++) wr_q.push_back(wdata_src[i]);
    @(negedge clk);
    mode      = 2'($urandom_range(0, 2));
    cmd_valid = 1'b1;
    cmd_dev   = dev;
    cmd_reg   = rg;
    cmd_rw    = rw;
    cmd_len   = 4'(len);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    chk("accept", ok, 1'b1);
    chk("accept_state", {busy, cmd_ready, err_nack, err_timeout, bytes_ok},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("m_mode", m_mode, mode);
  endtask

  task automatic finish_cmd(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (xfer_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, "_xfer_done"}, seen, 1'b1);
    @(negedge clk);
    chk({name, "_idle"}, {cmd_ready, busy}, 2'b10);
    chk({name, "_xfer_cnt"}, xfer_cnt, 1);
    chk({name, "_nops"}, ops_got.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < ops_got.size(); i++)
      chk($sformatf("%s_op%0d", name, i), ops_got[i], exp_ops[i]);
    chk({name, "_wr_ready_cnt"}, wr_cnt, exp_wr);
    chk({name, "_rd_cnt"}, rd_got.size(), exp_rd);
    for (int i = 0; i < exp_rd && i < rd_got.size(); i++)
      chk($sformatf("%s_rd%0d", name, i), rd_got[i], rd_src[i]);
    chk({name, "_status"}, {err_nack, err_timeout, bytes_ok},
        {exp_nack, 1'b0, 4'(exp_bytes)});
    wr_q.delete();
  endtask

  task automatic run_cmd(input string name, input logic [6:0] dev, input logic [7:0] rg,
                         input logic rw, input int len, input int nk);
    nack_at = nk;
    build_exp(dev, rg, rw, len, nk);
    start_cmd(dev, rg, rw, len);
    finish_cmd(name);
  endtask

  function automatic logic [29:0] out_vec();
    return {cmd_ready, busy, xfer_done, wr_ready, rd_valid, rd_data, err_nack,
            err_timeout, bytes_ok, m_start, m_restart, m_stop, m_rw, m_last, m_data};
  endfunction

  localparam logic [29:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                                     1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

  initial begin
    int   cyc;
    logic seen;
    rst = 1'b0; mode = 2'd0; cmd_valid = 1'b0; cmd_dev = 7'h00; cmd_reg = 8'h00;
    cmd_rw = 1'b0; cmd_len = 4'h0; eng_hang = 1'b0; nack_at = 99;
    wr_cnt = 0; xfer_cnt = 0; eng_idx = 0; rd_idx = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), RST_VEC);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write two bytes
    wdata_src[0] = 8'hA5; wdata_src[1] = 8'h3C;
    run_cmd("wr2", 7'h50, 8'h10, 1'b0, 2, 99);

    // Read three bytes
    rd_src[0] = 8'h11; rd_src[1] = 8'h22; rd_src[2] = 8'h33;
    run_cmd("rd3", 7'h68, 8'h75, 1'b1, 3, 99);

    // NACK on the address byte
    run_cmd("nack_aw", 7'h2C, 8'h01, 1'b0, 2, 0);

    // Pointer-set only, both directions
    run_cmd("len0_wr", 7'h50, 8'h05, 1'b0, 0, 99);
    run_cmd("len0_rd", 7'h50, 8'h06, 1'b1, 0, 99);

    // Engine accepts the address op and never finishes
    eng_hang = 1'b1;
    nack_at  = 99;
    wdata_src[0] = 8'h77;
    start_cmd(7'h50, 8'h20, 1'b0, 1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_start) begin seen = 1'b1; break; end
    end
    for (int k = 0; k < 50 && seen; k++) begin
      @(negedge clk);
      if (!m_start) break;
    end
    cyc = 0;
    while (!xfer_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_status", {err_timeout, err_nack, bytes_ok, m_start, m_stop},
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    @(negedge clk);
    chk("tmo_idle", {cmd_ready, busy}, 2'b10);
    chk("tmo_nops", ops_got.size(), 1);
    if (ops_got.size() > 0)
      chk("tmo_op0", ops_got[0], mk_op(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0));
    chk("tmo_xfer_cnt", xfer_cnt, 1);
    wr_q.delete();
    eng_hang = 1'b0;
    repeat (10) @(negedge clk);

    // Reset asserted during the second write data byte
    for (int i = 0; i < 4; i++) wdata_src[i] = 8'($urandom);
    nack_at = 99;
    start_cmd(7'h3A, 8'h44, 1'b0, 4);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (wr_cnt >= 2 && m_start) begin seen = 1'b1; break; end
    end
    chk("rst_reached_wd2", seen, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", out_vec(), RST_VEC);
    repeat (3) @(negedge clk);
    wr_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd("post_rst", 7'h3A, 8'h44, 1'b0, 4, 99);

    // Randomized commands
    for (int t = 0; t < 12; t++) begin
      logic [6:0] dev;
      logic [7:0] rg;
      logic       rw;
      int         len, nops, nk;
      dev = 7'($urandom);
      rg  = 8'($urandom);
      rw  = 1'($urandom);
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        wdata_src[i] = 8'($urandom);
        rd_src[i]    = 8'($urandom);
      end
      nops = 2 + ((len > 0) ? (rw ? len + 1 : len) : 0);
      nk   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nops - 1) : 99;
      run_cmd($sformatf("rnd%0d", t), dev, rg, rw, len, nk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iic_xfer_ctrl.md
# iic_xfer_ctrl

Register-level transaction sequencer for the I2C byte engine. It accepts one command (device address, register address, direction, byte count) and issues the byte operations for a complete write or combined read transfer: START+address, register pointer, data bytes, repeated START and STOP. It sits between the peripheral bus register block and the byte engine, streams write data in and read data out, and reports NACK and timeout errors.

## Interface
- TIMEOUT_CYC, 2_000_000: clk cycles allowed per engine operation before abort.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- mode  in  2  speed select, passed to engine unchanged (0 std, 1 fast, 2 high-speed)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_dev  in  7  7-bit device address
- cmd_reg  in  8  register address
- cmd_rw  in  1  0 write, 1 read
- cmd_len  in  4  data bytes, 0..15
- wr_valid / wr_data  in  1/8  write byte stream
- wr_ready  out  1  one-cycle pulse when wr_data is consumed
- rd_valid / rd_data  out  1/8  read byte; one-cycle pulse, no backpressure
- busy  out  1  command in progress
- xfer_done  out  1  one-cycle completion pulse
- err_nack, err_timeout  out  1  status, valid from xfer_done until next accept
- bytes_ok  out  4  data bytes completed in the last command
- m_start  out  1  byte-op request, held until m_done falls
- m_restart  out  1  with m_start: generate a START before the byte
- m_stop  out  1  STOP request, held until m_done falls
- m_rw  out  1  byte direction (0 send m_data, 1 receive)
- m_last  out  1  with read op: master sends NACK after byte
- m_data  out  8  byte to send
- m_mode  out  2  equals mode
- m_done  in  1  engine idle (high) / operation running (low)
- m_ack  in  1  slave acknowledge of last sent byte, 0 = ACK
- m_rdata  in  8  received byte, valid when m_done rises after a read op

## Operation
- Reset values: cmd_ready 1, busy 0, xfer_done 0, wr_ready 0, rd_valid 0, rd_data 0, err_* 0, bytes_ok 0, all m_* request outputs 0, m_data 0.
- Accept on cmd_valid && cmd_ready; latch all cmd_* fields, clear err_* and bytes_ok, busy=1.
- Phase sequence: AW (restart=1, data={dev,0}) -> REG (data=cmd_reg) -> if write: WD x len; if read and len>0: AR (restart=1, data={dev,1}) -> RD x len (m_rw=1, m_last on final) -> STOP.
- len=0: after REG go directly to STOP (pointer-set only), both directions.
- States: IDLE, FETCH, ISSUE, WAIT_ACC, WAIT_DONE, CHECK, STOP_REQ, STOP_WAIT, REPORT.
- FETCH (WD only): wait wr_valid; latch wr_data, pulse wr_ready, go to ISSUE.
- ISSUE: assert m_start (and m_restart for AW/AR) only when m_done=1; -> WAIT_ACC.
- WAIT_ACC: hold request until m_done=0, then drop request -> WAIT_DONE.
- WAIT_DONE: on m_done=1 -> CHECK.
- CHECK: on send ops, m_ack=1 sets err_nack -> STOP_REQ. On RD, pulse rd_valid with m_rdata. WD/RD increment bytes_ok. Otherwise advance the phase.
- STOP_REQ/STOP_WAIT: same request/accept/complete handshake as byte ops, using m_stop.
- REPORT: pulse xfer_done, busy=0 -> IDLE.
- Timeout: a cycle counter runs in WAIT_ACC, WAIT_DONE and STOP_WAIT and resets at each state entry. At TIMEOUT_CYC it sets err_timeout, drops all m_* requests and goes to REPORT without STOP.
- FETCH never times out; upstream must supply len bytes.
- Reset asserted mid-transfer: all outputs return to reset values immediately. No STOP is issued.

## Timing
- Accept edge -> m_start high on the next edge if m_done=1.
- m_done rising in WAIT_DONE -> CHECK next cycle -> next request 1 cycle later (min 2-cycle gap between byte ops).
- rd_valid is asserted in the CHECK cycle, 2 cycles after m_done rises.
- xfer_done is asserted 2 cycles after m_done rises at STOP completion. cmd_ready rises on the following edge.
- cmd_valid held while busy is ignored. It is accepted in the first IDLE cycle.
- m_start and m_stop are never high together. m_rw, m_data, m_restart and m_last are stable while a request is high.

## Test plan
- Write dev 0x50, reg 0x10, len 2, data 0xA5,0x3C, engine model all-ACK -> engine sees {0xA0 restart},{0x10},{0xA5},{0x3C},STOP. Two wr_ready pulses. xfer_done with bytes_ok=2, no errors.
- Read dev 0x68, reg 0x75, len 3, model returns 0x11,0x22,0x33 -> ops 0xD0(restart), 0x75, 0xD1(restart), 3 reads with m_last on the third only, then STOP. rd_valid x3 with 0x11,0x22,0x33. bytes_ok=3.
- NACK on address byte -> no REG op, STOP issued, err_nack=1, bytes_ok=0.
- len=0 write to reg 0x05 -> AW, REG, STOP only. wr_ready never pulses.
- Engine model never raises m_done, TIMEOUT_CYC=100 -> err_timeout after 100 cycles in WAIT_DONE, no m_stop, xfer_done pulses, cmd_ready returns to 1.
- rst low during the second WD byte -> all outputs at reset values in the same cycle. A new command after release completes normally.
